// File: rtl/common_pkg.sv
// Shared pipeline types: thread/register ids, pointer and word types,
// DTLB page numbers and the physical address type used by the data memory.
package common;

    localparam int n_threads     = 4;
    localparam int PAGE_BITS_DEF = 12;

    typedef logic [$clog2(n_threads)-1:0] threadid_t;
    typedef logic [4:0]                   regid_t;
    typedef logic [31:0]                  vptr_t;
    typedef logic [31:0]                  word_t;
    typedef logic [19:0]                  vpn_t;
    typedef logic [7:0]                   ppn_t;

    typedef enum logic [1:0] {
        TLBW_NONE = 2'd0,
        TLBW_ITLB = 2'd1,
        TLBW_DTLB = 2'd2
    } tlbwrite_t;

    // Physical address: page frame number concatenated with the page offset.
    typedef logic [$bits(ppn_t)+PAGE_BITS_DEF-1:0] paddr_t;

endpackage

// File: rtl/stage_tl_pkg.sv
// Local definitions of the translate/load stage: FSM state encoding,
// counter limit and the memory-operation qualifier.
package stage_tl_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } tl_state_t;

    localparam logic [15:0] MISS_CNT_MAX = 16'hFFFF;

    // A memory op only touches the DTLB/memory when the instruction is live.
    function automatic logic is_mem_op(input logic flag_mem, input logic isvalid);
        return flag_mem & isvalid;
    endfunction

endpackage

// File: rtl/stage_tl_if.sv
// Data-memory bus between the translate/load stage (master) and memory (slave).
// The address is a physical address: {ppn, page offset}.
interface stage_tl_if #(
    parameter int PAGE_BITS = 12
);
    import common::*;

    localparam int PA_BITS = $bits(ppn_t) + PAGE_BITS;

    logic               mem_req;
    logic               mem_we;
    logic [3:0]         mem_be;
    logic [PA_BITS-1:0] mem_addr;
    word_t              mem_wdata;
    logic               mem_ack;
    word_t              mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/tl_byte_lane.sv
// Byte-lane steering for the data memory: byte enables, store data
// replication and load byte extraction (zero-extended). Purely combinational.
module tl_byte_lane
    import common::*;
(
    input  logic       isbyte,
    input  logic [1:0] byte_off,
    input  word_t      store_data,
    input  word_t      load_data,
    output logic [3:0] be,
    output word_t      wdata,
    output word_t      load_word
);

    logic [7:0] lanes [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        // Word access enables every lane; byte access enables only the addressed one.
        assign be[gi]           = !isbyte || (byte_off == 2'(gi));
        // Byte stores put the low byte on every lane so memory can pick any of them.
        assign wdata[8*gi +: 8] = isbyte ? store_data[7:0] : store_data[8*gi +: 8];
        assign lanes[gi]        = load_data[8*gi +: 8];
    end

    assign load_word = isbyte ? {24'h0, lanes[byte_off]} : load_data;

endmodule

// File: rtl/stage_tl.sv
// Translate/load stage: looks up the DTLB for memory ops, performs the data
// memory access (holding the pipeline with stall until mem_ack) and hands a
// registered tl_* bundle to writeback as a one-cycle tl_valid pulse.
// Optional feature: define STAGE_TL_MISS_COUNT_EN to add per-thread
// saturating DTLB miss counters on port dtlb_miss_cnt.
module stage_tl
    import common::*;
    import stage_tl_pkg::*;
#(
    parameter int PAGE_BITS = 12
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       ex_valid,
    input  threadid_t  ex_thread,
    input  logic       ex_isvalid,
    input  logic       ex_itlb_miss,
    input  regid_t     ex_dst,
    input  vptr_t      ex_pc,
    input  word_t      ex_r2,
    input  word_t      ex_alu,
    input  logic       ex_isequal,
    input  word_t      ex_mul,
    input  logic       ex_flag_mem,
    input  logic       ex_flag_store,
    input  logic       ex_flag_isbyte,
    input  logic       ex_flag_mul,
    input  logic       ex_flag_reg,
    input  logic       ex_flag_jump,
    input  logic       ex_flag_branch,
    input  logic       ex_flag_iret,
    input  tlbwrite_t  ex_flag_tlbwrite,

    output logic       stall,

    output vpn_t       dtlb_vpn,
    input  ppn_t       dtlb_ppn,
    input  logic       dtlb_hit,

    stage_tl_if.master mem,

`ifdef STAGE_TL_MISS_COUNT_EN
    output logic [15:0] dtlb_miss_cnt [n_threads],
`endif

    output logic       tl_valid,
    output threadid_t  tl_thread,
    output logic       tl_isvalid,
    output logic       tl_itlb_miss,
    output logic       tl_dtlb_miss,
    output regid_t     tl_dst,
    output vptr_t      tl_pc,
    output word_t      tl_r2,
    output word_t      tl_data,
    output logic       tl_isequal,
    output word_t      tl_mul,
    output logic       tl_flag_mul,
    output logic       tl_flag_reg,
    output logic       tl_flag_jump,
    output logic       tl_flag_branch,
    output logic       tl_flag_iret,
    output tlbwrite_t  tl_flag_tlbwrite
);

    localparam int PA_BITS = $bits(ppn_t) + PAGE_BITS;

    tl_state_t          state_reg;
    logic               pend_isbyte_reg;
    logic               pend_store_reg;
    logic [1:0]         pend_off_reg;

    logic               is_mem;
    logic [PA_BITS-1:0] pa_next;
    logic               lane_isbyte;
    logic [1:0]         lane_off;
    logic [3:0]         lane_be;
    word_t              lane_wdata;
    word_t              lane_load;

    assign is_mem   = is_mem_op(ex_flag_mem, ex_isvalid);
    assign stall    = (state_reg == ST_ACCESS);
    assign dtlb_vpn = ex_alu[PAGE_BITS +: $bits(vpn_t)];

    // Physical address of the access; word accesses are forced to word alignment.
    always_comb begin
        pa_next = {dtlb_ppn, ex_alu[PAGE_BITS-1:0]};
        if (!ex_flag_isbyte) begin
            pa_next[1:0] = 2'b00;
        end
    end

    // In IDLE the lanes steer the incoming store; in ACCESS they extract the load.
    assign lane_isbyte = (state_reg == ST_IDLE) ? ex_flag_isbyte : pend_isbyte_reg;
    assign lane_off    = (state_reg == ST_IDLE) ? ex_alu[1:0]    : pend_off_reg;

    tl_byte_lane u_byte_lane (
        .isbyte     (lane_isbyte),
        .byte_off   (lane_off),
        .store_data (ex_r2),
        .load_data  (mem.mem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_word  (lane_load)
    );

    // Stage FSM: accept in IDLE, wait for the memory ack in ACCESS; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            pend_isbyte_reg  <= 1'b0;
            pend_store_reg   <= 1'b0;
            pend_off_reg     <= 2'b00;
            mem.mem_req      <= 1'b0;
            mem.mem_we       <= 1'b0;
            mem.mem_be       <= 4'b0000;
            mem.mem_addr     <= '0;
            mem.mem_wdata    <= '0;
            tl_valid         <= 1'b0;
            tl_thread        <= '0;
            tl_isvalid       <= 1'b0;
            tl_itlb_miss     <= 1'b0;
            tl_dtlb_miss     <= 1'b0;
            tl_dst           <= '0;
            tl_pc            <= '0;
            tl_r2            <= '0;
            tl_data          <= '0;
            tl_isequal       <= 1'b0;
            tl_mul           <= '0;
            tl_flag_mul      <= 1'b0;
            tl_flag_reg      <= 1'b0;
            tl_flag_jump     <= 1'b0;
            tl_flag_branch   <= 1'b0;
            tl_flag_iret     <= 1'b0;
            tl_flag_tlbwrite <= TLBW_NONE;
        end else begin
            tl_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ex_valid) begin
                        // Passthrough fields are captured once at accept time.
                        tl_thread        <= ex_thread;
                        tl_isvalid       <= ex_isvalid;
                        tl_itlb_miss     <= ex_itlb_miss;
                        tl_dtlb_miss     <= 1'b0;
                        tl_dst           <= ex_dst;
                        tl_pc            <= ex_pc;
                        tl_r2            <= ex_r2;
                        tl_data          <= ex_alu;
                        tl_isequal       <= ex_isequal;
                        tl_mul           <= ex_mul;
                        tl_flag_mul      <= ex_flag_mul;
                        tl_flag_reg      <= ex_flag_reg;
                        tl_flag_jump     <= ex_flag_jump;
                        tl_flag_branch   <= ex_flag_branch;
                        tl_flag_iret     <= ex_flag_iret;
                        tl_flag_tlbwrite <= ex_flag_tlbwrite;
                        if (is_mem && !dtlb_hit) begin
                            // DTLB miss: kill the instruction, report the faulting VA.
                            tl_valid     <= 1'b1;
                            tl_isvalid   <= 1'b0;
                            tl_dtlb_miss <= 1'b1;
                        end else if (is_mem) begin
                            state_reg       <= ST_ACCESS;
                            mem.mem_req     <= 1'b1;
                            mem.mem_we      <= ex_flag_store;
                            mem.mem_be      <= lane_be;
                            mem.mem_addr    <= pa_next;
                            mem.mem_wdata   <= lane_wdata;
                            pend_isbyte_reg <= ex_flag_isbyte;
                            pend_store_reg  <= ex_flag_store;
                            pend_off_reg    <= ex_alu[1:0];
                        end else begin
                            tl_valid <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem.mem_ack) begin
                        // Stores keep the VA already in tl_data; loads take memory data.
                        state_reg   <= ST_IDLE;
                        mem.mem_req <= 1'b0;
                        tl_valid    <= 1'b1;
                        if (!pend_store_reg) begin
                            tl_data <= lane_load;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef STAGE_TL_MISS_COUNT_EN
    logic        miss_event;
    logic [15:0] miss_cnt_reg [n_threads];

    assign miss_event = (state_reg == ST_IDLE) && ex_valid && is_mem && !dtlb_hit;

    for (genvar gi = 0; gi < n_threads; gi++) begin : g_miss_cnt
        // Saturating per-thread count of DTLB misses seen at accept.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                miss_cnt_reg[gi] <= '0;
            end else if (miss_event && (ex_thread == threadid_t'(gi))
                         && (miss_cnt_reg[gi] != MISS_CNT_MAX)) begin
                miss_cnt_reg[gi] <= miss_cnt_reg[gi] + 16'd1;
            end
        end
        assign dtlb_miss_cnt[gi] = miss_cnt_reg[gi];
    end
`endif

endmodule
